// File: rtl/l2_mem_responder_pkg.sv
// Shared types for the L2 memory responder, plus cache parameter defaults
// (line size, offset width, depth, latencies) used when the build does not override them.
`ifndef L2_LINE_SIZE
`define L2_LINE_SIZE 32
`endif
`ifndef L2_OFFSET_WIDTH
`define L2_OFFSET_WIDTH 5
`endif
`ifndef MEM_DEPTH_LINES
`define MEM_DEPTH_LINES 1024
`endif
`ifndef MEM_RD_LATENCY
`define MEM_RD_LATENCY 4
`endif
`ifndef MEM_WR_LATENCY
`define MEM_WR_LATENCY 4
`endif

package l2_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// L2 <-> memory line request bus; requests are level-held until mem_ready.
// master = L2 side, slave = memory responder side.
interface l2_mem_responder_if
    import l2_mem_responder_pkg::*;
#(
    parameter int LINE_SIZE = `L2_LINE_SIZE
);
    logic [31:0]            mem_addr;
    logic [LINE_SIZE*8-1:0] mem_wdata;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [LINE_SIZE*8-1:0] mem_rdata;
    logic                   mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous write, registered read output that holds between reads.
// Storage itself is never reset; only the read register clears on reset.
module mem_line_array #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/l2_mem_responder.sv
// Fixed-latency line memory model: mem_ready pulses RD/WR_LATENCY edges after capture, then waits for
// the request to drop (DRAIN) so held requests are never re-captured. Optional stats: L2_MEM_STATS_EN.
module l2_mem_responder
    import l2_mem_responder_pkg::*;
#(
    parameter int LINE_SIZE    = `L2_LINE_SIZE,
    parameter int OFFSET_WIDTH = `L2_OFFSET_WIDTH,
    parameter int DEPTH_LINES  = `MEM_DEPTH_LINES,
    parameter int RD_LATENCY   = `MEM_RD_LATENCY,
    parameter int WR_LATENCY   = `MEM_WR_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    l2_mem_responder_if.slave   mem,
    output logic                err_both,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(max_int(RD_LATENCY, WR_LATENCY)) + 1;
    localparam int LW    = LINE_SIZE * 8;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LW-1:0]      wdata_q, wdata_d;
    op_t                op_q, op_d;
    logic               err_q, err_d;
    logic               arr_en, arr_we;
    logic [LW-1:0]      arr_rdata;

    wire unused_addr_bits = ^mem.mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = err_q;
        arr_en  = 1'b0;
        arr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem.mem_rd || mem.mem_wr) begin
                    idx_d   = mem.mem_addr[OFFSET_WIDTH +: IDX_W];
                    wdata_d = mem.mem_wdata;
                    // Write wins a simultaneous request; the collision is latched as an error.
                    op_d    = mem.mem_wr ? OP_WR : OP_RD;
                    cnt_d   = mem.mem_wr ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
                    err_d   = err_q | (mem.mem_rd & mem.mem_wr);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    arr_en  = 1'b1;
                    arr_we  = (op_q == OP_WR);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!mem.mem_rd && !mem.mem_wr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_line_array #(
        .WIDTH (LW),
        .DEPTH (DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mem.mem_rdata = arr_rdata;
    assign mem.mem_ready = (state_q == RESP);
    assign err_both      = err_q;

`ifdef L2_MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    // Counters bump on the same edge that raises mem_ready and saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (arr_en) begin
            if (!arr_we && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (arr_we  && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed + randomized bench for l2_mem_responder against a line-array reference model.
module tb_l2_mem_responder;
    localparam int LS    = 32;
    localparam int OW    = 5;
    localparam int DEPTH = 64;
    localparam int RDL   = 4;
    localparam int WRL   = 4;
`ifdef L2_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_both;
    logic [31:0] rd_count, wr_count;

    always #5 clk = ~clk;

    l2_mem_responder_if #(.LINE_SIZE(LS)) bus();

    l2_mem_responder #(
        .LINE_SIZE    (LS),
        .OFFSET_WIDTH (OW),
        .DEPTH_LINES  (DEPTH),
        .RD_LATENCY   (RDL),
        .WR_LATENCY   (WRL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (bus),
        .err_both (err_both),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    int total = 0;
    int bad = 0;
    int rd_exp = 0;
    int wr_exp = 0;
    logic [255:0] model [int];
    logic [255:0] last_rd = '0;
    int pool [6] = '{8, 16, 24, 32, 33, 40};

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> OW) % DEPTH);
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.mem_ready && lat < 20);
    endtask

    // Check the pulse is a single cycle, hold the request `extra` more cycles, then drop it.
    task automatic finish_txn(input int extra);
        for (int i = 0; i <= extra; i++) begin
            @(posedge clk); #1;
            chk("single_pulse", {255'd0, bus.mem_ready}, 256'd0);
        end
        @(negedge clk);
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic check_counts();
        chk("rd_count", {224'd0, rd_count}, {224'd0, cnt_exp(rd_exp)});
        chk("wr_count", {224'd0, wr_count}, {224'd0, cnt_exp(wr_exp)});
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] wd, input int extra);
        int lat;
        int k;
        @(negedge clk);
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        @(posedge clk);
        wait_ready(lat);
        k = idx_of(a);
        if (wr) begin
            chk("wr_latency", 256'(lat), 256'(WRL));
            model[k] = wd;
            wr_exp++;
            chk("wr_keeps_rdata", bus.mem_rdata, last_rd);
        end else begin
            chk("rd_latency", 256'(lat), 256'(RDL));
            rd_exp++;
            chk("rd_data", bus.mem_rdata, model[k]);
            last_rd = model[k];
        end
        check_counts();
        finish_txn(extra);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d_y, d_x, d0, d1, d2, d;
        int lat;
        int p;
        logic saw;
        logic w;
        logic [31:0] a;

        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {255'd0, bus.mem_ready}, 256'd0);
        chk("rst_rdata", bus.mem_rdata, 256'd0);
        chk("rst_err", {255'd0, err_both}, 256'd0);
        check_counts();
        @(negedge clk) rst_n = 1'b1;

        // Basic write then read of the same line, read held extra cycles
        txn(1'b0, 1'b1, 32'h0000_0100, {32{8'hA5}}, 0);
        txn(1'b1, 1'b0, 32'h0000_0100, 256'd0, 0);
        txn(1'b1, 1'b0, 32'h0000_0100, 256'd0, 2);
        // Writeback then immediate read of the same line
        d = {8{$urandom()}};
        txn(1'b0, 1'b1, 32'h0000_0200, d, 0);
        txn(1'b1, 1'b0, 32'h0000_0200, 256'd0, 0);
        // Aliased address (upper index bits beyond DEPTH) maps onto line 8
        txn(1'b1, 1'b0, 32'h0000_0100 + 32'(DEPTH << OW) + 32'd7, 256'd0, 1);
        // Simultaneous read+write: write wins, error is sticky
        d = {8{$urandom()}};
        txn(1'b1, 1'b1, 32'h0000_0500, d, 0);
        chk("err_both_set", {255'd0, err_both}, 256'd1);
        txn(1'b1, 1'b0, 32'h0000_0500, 256'd0, 0);
        chk("err_both_sticky", {255'd0, err_both}, 256'd1);

        // Reset during BUSY aborts the pending write
        d_y = {8{$urandom()}};
        d_x = ~d_y;
        txn(1'b0, 1'b1, 32'h0000_0300, d_y, 0);
        @(negedge clk);
        bus.mem_wr = 1'b1; bus.mem_addr = 32'h0000_0300; bus.mem_wdata = d_x;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_wr = 1'b0;
        saw = 1'b0;
        repeat (2) begin @(posedge clk); #1; saw |= bus.mem_ready; end
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; saw |= bus.mem_ready; end
        chk("abort_no_ready", {255'd0, saw}, 256'd0);
        rd_exp = 0; wr_exp = 0; last_rd = '0;
        chk("rst2_err", {255'd0, err_both}, 256'd0);
        chk("rst2_rdata", bus.mem_rdata, 256'd0);
        check_counts();
        txn(1'b1, 1'b0, 32'h0000_0300, 256'd0, 0);

        // Request inputs changing during BUSY are ignored
        d0 = {8{$urandom()}};
        d1 = {8{$urandom()}};
        d2 = {8{$urandom()}};
        txn(1'b0, 1'b1, 32'h0000_0420, d0, 0);
        @(negedge clk);
        bus.mem_wr = 1'b1; bus.mem_rd = 1'b0; bus.mem_addr = 32'h0000_0400; bus.mem_wdata = d1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h0000_0420; bus.mem_wdata = d2;
        wait_ready(lat);
        chk("busy_change_latency", 256'(lat), 256'(WRL));
        model[idx_of(32'h0000_0400)] = d1;
        wr_exp++;
        check_counts();
        finish_txn(0);
        chk("busy_change_no_err", {255'd0, err_both}, 256'd0);
        txn(1'b1, 1'b0, 32'h0000_0400, 256'd0, 0);
        txn(1'b1, 1'b0, 32'h0000_0420, 256'd0, 0);

        // Randomized traffic over previously written lines with random upper bits/offsets
        for (int n = 0; n < 40; n++) begin
            p = $urandom_range(0, 5);
            a = ($urandom() & 32'hFFFF_F800) | 32'(pool[p] << OW) | 32'($urandom_range(0, 31));
            w = 1'($urandom_range(0, 1));
            d = {8{$urandom()}};
            txn(~w, w, a, d, $urandom_range(0, 3));
        end
        chk("final_err", {255'd0, err_both}, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
